// File: rtl/fb_line_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : fb_line_fetch
//  Description : Framebuffer line fetcher for the display path. On each
//                source line it reads one framebuffer row from a simple
//                dual-port BRAM and streams it into the linebuffer. Each row
//                is repeated over FB_SCALE display lines. Runs entirely in
//                the system clock domain; the display flags must already be
//                synchronised into it.
//
//  Ports       : clk      - system clock
//                rst      - synchronous active-high reset
//                frame    - start-of-frame pulse (returns to IDLE)
//                line     - start-of-line pulse
//                line0    - first content line pulse (restarts the fetch)
//                fb_addr  - BRAM read address
//                fb_re    - read strobe (informational)
//                fb_data  - BRAM read data, RD_LAT cycles after fb_addr
//                lb_we    - linebuffer write enable
//                lb_data  - linebuffer write data
//                row      - row currently or last fetched
//                busy     - high while a row fetch is in progress
//                overrun  - sticky: a line arrived while fetching
//
//  Options     : define FB_LINE_FETCH_OVERRUN_EN to enable the sticky
//                overrun flag; otherwise overrun is tied low. The fetch
//                abort on a mid-fetch line happens either way.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_line_fetch #(
    parameter int FB_WIDTH  = 320,
    parameter int FB_HEIGHT = 180,
    parameter int FB_SCALE  = 2,
    parameter int ADDRW     = $clog2(FB_WIDTH * FB_HEIGHT),
    parameter int DATAW     = 8,
    parameter int RD_LAT    = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame,
    input  logic                         line,
    input  logic                         line0,
    output logic [ADDRW-1:0]             fb_addr,
    output logic                         fb_re,
    input  logic [DATAW-1:0]             fb_data,
    output logic                         lb_we,
    output logic [DATAW-1:0]             lb_data,
    output logic [$clog2(FB_HEIGHT)-1:0] row,
    output logic                         busy,
    output logic                         overrun
);

    localparam int ROWW = $clog2(FB_HEIGHT);
    localparam int COLW = $clog2(FB_WIDTH + 1);
    localparam int SCW  = 6;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_FETCH = 2'd1;
    localparam logic [1:0] c_S_HOLD  = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    localparam logic [ADDRW-1:0] c_WIDTH_A  = ADDRW'(FB_WIDTH);
    localparam logic [COLW-1:0]  c_COL_LAST = COLW'(FB_WIDTH);
    localparam logic [ROWW-1:0]  c_ROW_LAST = ROWW'(FB_HEIGHT - 1);
    localparam logic [SCW-1:0]   c_SC_LAST  = SCW'(FB_SCALE - 1);

    logic [1:0]       r_state;
    logic [ADDRW-1:0] r_addr;
    logic [ADDRW-1:0] r_base;
    logic [COLW-1:0]  r_col;     // number of reads issued for the current row
    logic [ROWW-1:0]  r_row;
    logic [SCW-1:0]   r_scale;

    logic             w_line_hit;
    logic             w_wrap;
    logic             w_last_row;
    logic             w_last_read;
    logic [ADDRW-1:0] w_next_base;

    // A line is only meaningful while a row is being fetched or held; in
    // FETCH it abandons the rest of the row and is handled like a HOLD line.
    assign w_line_hit  = line && ((r_state == c_S_FETCH) || (r_state == c_S_HOLD));
    assign w_wrap      = (r_scale == c_SC_LAST);
    assign w_last_row  = (r_row == c_ROW_LAST);
    assign w_last_read = (r_col == c_COL_LAST);
    // Row base advances by one row width per row; no multiplier needed.
    assign w_next_base = r_base + c_WIDTH_A;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_addr  <= '0;
            r_base  <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_scale <= '0;
        end else if (line0) begin
            r_state <= c_S_FETCH;
            r_addr  <= '0;
            r_base  <= '0;
            r_col   <= COLW'(1);
            r_row   <= '0;
            r_scale <= '0;
        end else if (frame) begin
            r_state <= c_S_IDLE;
        end else if (w_line_hit) begin
            if (w_wrap) begin
                r_scale <= '0;
                if (w_last_row) begin
                    // Final row already shown; row and base stay put.
                    r_state <= c_S_DONE;
                end else begin
                    r_state <= c_S_FETCH;
                    r_row   <= r_row + ROWW'(1);
                    r_base  <= w_next_base;
                    r_addr  <= w_next_base;
                    r_col   <= COLW'(1);
                end
            end else begin
                r_scale <= r_scale + SCW'(1);
                r_state <= c_S_HOLD;
            end
        end else if (r_state == c_S_FETCH) begin
            if (w_last_read) begin
                r_state <= c_S_HOLD;
            end else begin
                r_addr <= r_addr + ADDRW'(1);
                r_col  <= r_col + COLW'(1);
            end
        end
    end

    assign fb_addr = r_addr;
    assign fb_re   = (r_state == c_S_FETCH);
    assign busy    = (r_state == c_S_FETCH);
    assign row     = r_row;
    assign lb_data = fb_data;

    // Read strobe delayed by the BRAM latency marks valid linebuffer data.
    // In-flight strobes of an abandoned row still drain out here.
    generate
        if (RD_LAT == 1) begin : g_lat_one
            logic r_re_d;
            always_ff @(posedge clk) begin
                if (rst) r_re_d <= 1'b0;
                else     r_re_d <= fb_re;
            end
            assign lb_we = r_re_d;
        end else begin : g_lat_multi
            logic [RD_LAT-1:0] r_re_sr;
            always_ff @(posedge clk) begin
                if (rst) r_re_sr <= '0;
                else     r_re_sr <= {r_re_sr[RD_LAT-2:0], fb_re};
            end
            assign lb_we = r_re_sr[RD_LAT-1];
        end
    endgenerate

`ifdef FB_LINE_FETCH_OVERRUN_EN
    logic r_overrun;
    always_ff @(posedge clk) begin
        if (rst)
            r_overrun <= 1'b0;
        else if (frame)
            r_overrun <= 1'b0;
        else if (!line0 && line && (r_state == c_S_FETCH))
            r_overrun <= 1'b1;
    end
    assign overrun = r_overrun;
`else
    assign overrun = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fb_line_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fb_line_fetch
//  Description : Self-checking bench for fb_line_fetch. Three instances share
//                the control stimulus: A (W8 H3 S2 L1), B (W8 H3 S2 L2) and
//                C (W8 H3 S1 L1). Each BRAM model returns addr+1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_line_fetch;

    localparam int W  = 8;
    localparam int H  = 3;
    localparam int AW = 5;
    localparam int DW = 8;
    localparam int RW = 2;

    localparam int EV_RST   = 0;
    localparam int EV_LINE0 = 1;
    localparam int EV_LINE  = 2;
    localparam int EV_FRAME = 3;
    localparam int EV_FR_LN = 4;
    localparam int EV_L0_FR = 5;

`ifdef FB_LINE_FETCH_OVERRUN_EN
    localparam int EXP_OVR = 1;
`else
    localparam int EXP_OVR = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0, frame = 1'b0, line = 1'b0, line0 = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] addr_a, addr_b, addr_c;
    logic          re_a, re_b, re_c, we_a, we_b, we_c;
    logic          busy_a, busy_b, busy_c, ov_a, ov_b, ov_c;
    logic [DW-1:0] dat_a, dat_b, dat_c, b1, lbd_a, lbd_b, lbd_c;
    logic [RW-1:0] row_a, row_b, row_c;

    fb_line_fetch #(.FB_WIDTH(W), .FB_HEIGHT(H), .FB_SCALE(2), .ADDRW(AW), .DATAW(DW), .RD_LAT(1)) u_a (
        .clk(clk), .rst(rst), .frame(frame), .line(line), .line0(line0),
        .fb_addr(addr_a), .fb_re(re_a), .fb_data(dat_a), .lb_we(we_a), .lb_data(lbd_a),
        .row(row_a), .busy(busy_a), .overrun(ov_a));

    fb_line_fetch #(.FB_WIDTH(W), .FB_HEIGHT(H), .FB_SCALE(2), .ADDRW(AW), .DATAW(DW), .RD_LAT(2)) u_b (
        .clk(clk), .rst(rst), .frame(frame), .line(line), .line0(line0),
        .fb_addr(addr_b), .fb_re(re_b), .fb_data(dat_b), .lb_we(we_b), .lb_data(lbd_b),
        .row(row_b), .busy(busy_b), .overrun(ov_b));

    fb_line_fetch #(.FB_WIDTH(W), .FB_HEIGHT(H), .FB_SCALE(1), .ADDRW(AW), .DATAW(DW), .RD_LAT(1)) u_c (
        .clk(clk), .rst(rst), .frame(frame), .line(line), .line0(line0),
        .fb_addr(addr_c), .fb_re(re_c), .fb_data(dat_c), .lb_we(we_c), .lb_data(lbd_c),
        .row(row_c), .busy(busy_c), .overrun(ov_c));

    // BRAM models: data = addr + 1 after the instance's read latency
    always @(posedge clk) begin
        dat_a <= {3'b000, addr_a} + 8'd1;
        b1    <= {3'b000, addr_b} + 8'd1;
        dat_b <= b1;
        dat_c <= {3'b000, addr_c} + 8'd1;
    end

    // Observed instance selected by sel
    int            sel = 0;
    logic          s_re, s_we, s_busy, s_ov;
    logic [AW-1:0] s_addr;
    logic [RW-1:0] s_row;
    logic [DW-1:0] s_data;
    always_comb begin
        s_re = re_a; s_we = we_a; s_busy = busy_a; s_ov = ov_a;
        s_addr = addr_a; s_row = row_a; s_data = lbd_a;
        case (sel)
            1: begin
                s_re = re_b; s_we = we_b; s_busy = busy_b; s_ov = ov_b;
                s_addr = addr_b; s_row = row_b; s_data = lbd_b;
            end
            2: begin
                s_re = re_c; s_we = we_c; s_busy = busy_c; s_ov = ov_c;
                s_addr = addr_c; s_row = row_c; s_data = lbd_c;
            end
            default: ;
        endcase
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Called just after a falling edge: holds the flag(s) for one cycle and
    // returns on the next falling edge, i.e. in the cycle after the pulse.
    task automatic pulse(input int ev);
        rst   = (ev == EV_RST);
        line0 = (ev == EV_LINE0) || (ev == EV_L0_FR);
        line  = (ev == EV_LINE)  || (ev == EV_FR_LN);
        frame = (ev == EV_FRAME) || (ev == EV_FR_LN) || (ev == EV_L0_FR);
        @(negedge clk);
        rst = 1'b0; line0 = 1'b0; line = 1'b0; frame = 1'b0;
    endtask

    // Observes 20 cycles; checks read count, first/last address, row, busy.
    task automatic window(input string nm, input int en, input int ef, input int er);
        int n = 0, first = -1, last = -1, bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (s_re) begin
                if (n == 0) first = int'(s_addr);
                last = int'(s_addr);
                n++;
            end
            if (s_busy != s_re) bad = 1;
            @(negedge clk);
        end
        chk({nm, "_nreads"}, n, en);
        if (en > 0) begin
            chk({nm, "_first"}, first, ef);
            chk({nm, "_last"}, last, ef + en - 1);
        end
        chk({nm, "_row"}, int'(s_row), er);
        chk({nm, "_busy_eq_re"}, bad, 0);
    endtask

    typedef struct {
        int sel;
        int ev;
        int n;
        int first;
        int row;
    } vec_t;

    vec_t vt [0:21];

    initial begin
        // Instance A: line0 then lines, scale 2, three rows, DONE, frame
        vt[0]  = '{0, EV_RST,   0, 0,  0};
        vt[1]  = '{0, EV_LINE0, 8, 0,  0};
        vt[2]  = '{0, EV_LINE,  0, 0,  0};
        vt[3]  = '{0, EV_LINE,  8, 8,  1};
        vt[4]  = '{0, EV_LINE,  0, 0,  1};
        vt[5]  = '{0, EV_LINE,  8, 16, 2};
        vt[6]  = '{0, EV_LINE,  0, 0,  2};
        vt[7]  = '{0, EV_LINE,  0, 0,  2};
        vt[8]  = '{0, EV_LINE,  0, 0,  2};
        vt[9]  = '{0, EV_FRAME, 0, 0,  2};
        vt[10] = '{0, EV_LINE,  0, 0,  2};
        vt[11] = '{0, EV_LINE0, 8, 0,  0};
        // Instance A: coincident flags
        vt[12] = '{0, EV_RST,   0, 0,  0};
        vt[13] = '{0, EV_LINE0, 8, 0,  0};
        vt[14] = '{0, EV_FR_LN, 0, 0,  0};
        vt[15] = '{0, EV_LINE,  0, 0,  0};
        vt[16] = '{0, EV_L0_FR, 8, 0,  0};
        // Instance C: scale 1, rows 0..2 then no further reads
        vt[17] = '{2, EV_RST,   0, 0,  0};
        vt[18] = '{2, EV_LINE0, 8, 0,  0};
        vt[19] = '{2, EV_LINE,  8, 8,  1};
        vt[20] = '{2, EV_LINE,  8, 16, 2};
        vt[21] = '{2, EV_LINE,  0, 0,  2};

        @(negedge clk);
        for (int i = 0; i < 22; i++) begin
            sel = vt[i].sel;
            pulse(vt[i].ev);
            if (vt[i].ev == EV_RST)
                chk($sformatf("v%0d_reset_state", i),
                    int'({s_re, s_we, s_busy, s_ov, s_addr, s_row}), 0);
            window($sformatf("v%0d", i), vt[i].n, vt[i].first, vt[i].row);
        end

        // Read-latency alignment on instance B (RD_LAT=2)
        sel = 1;
        pulse(EV_RST);
        pulse(EV_LINE0);
        for (int k = 1; k <= 11; k++) begin
            chk($sformatf("lat_we_t%0d", k), int'(s_we), (k >= 3 && k <= 10) ? 1 : 0);
            if (k >= 3 && k <= 10)
                chk($sformatf("lat_data_t%0d", k), int'(s_data), k - 2);
            @(negedge clk);
        end

        // Overrun on instance C: line during the 4th read of row 0
        sel = 2;
        pulse(EV_RST);
        pulse(EV_LINE0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ovr_read%0d_re", k), int'(s_re), 1);
            chk($sformatf("ovr_read%0d_addr", k), int'(s_addr), k);
            if (k < 3) @(negedge clk);
        end
        pulse(EV_LINE);
        chk("ovr_next_addr", int'(s_addr), 8);
        chk("ovr_next_row", int'(s_row), 1);
        chk("ovr_flag", int'(s_ov), EXP_OVR);
        window("ovr_next", 8, 8, 1);
        chk("ovr_sticky", int'(s_ov), EXP_OVR);
        pulse(EV_FRAME);
        chk("ovr_clear_on_frame", int'(s_ov), 0);

        // Reset in the middle of the row-1 fetch on instance A
        sel = 0;
        pulse(EV_RST);
        pulse(EV_LINE0);
        window("rm_r0", 8, 0, 0);
        pulse(EV_LINE);
        window("rm_l1", 0, 0, 0);
        pulse(EV_LINE);
        repeat (5) @(negedge clk);
        chk("rm_pre_addr", int'(s_addr), 13);
        chk("rm_pre_row", int'(s_row), 1);
        pulse(EV_RST);
        chk("rm_re", int'(s_re), 0);
        chk("rm_we", int'(s_we), 0);
        chk("rm_addr", int'(s_addr), 0);
        chk("rm_row", int'(s_row), 0);
        chk("rm_busy", int'(s_busy), 0);
        window("rm_idle", 0, 0, 0);
        pulse(EV_LINE0);
        window("rm_restart", 8, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
